uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmit path for the character link. It accepts one parallel data word over a valid/ready handshake and serializes it onto tx_serial, LSB first. The frame is a start bit, DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits. Bit timing comes from the same 16x oversample tick (tick16) that drives the receive-side bit sample counter, so one bit period equals OVERSAMPLE tick16 pulses.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
OVERSAMPLE, 16, tick16 pulses per bit period (power of two, 4..16)
STOP_BITS, 1, number of stop bits (1 or 2)
PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-low reset
tick16  input  1  oversample enable, one-clk pulse per 1/OVERSAMPLE bit time
tx_data  input  DATA_BITS  word to send, sampled only on accept
tx_valid  input  1  producer has a word
tx_ready  output  1  block can accept a word (high only in IDLE)
tx_serial  output  1  serial line, idle high
tx_busy  output  1  frame in progress (any state other than IDLE)
tx_done  output  1  one-clk pulse at the end of the last stop bit

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Shift register, tick counter and bit counter are cleared.
  - Reset mid-frame aborts the frame; the line returns high at that edge with no partial stop bit.
- States: IDLE, START, DATA, PARITY (only with UART_TX_PARITY_EN), STOP.
- Accept: a word is accepted when tx_valid && tx_ready at posedge.
  - tx_data is latched into the shift register at that edge.
  - The state goes to START and the tick counter is cleared.
  - tx_serial=0 from that edge onward, so latency from accept to start bit is 1 clk.
- tx_valid while busy is ignored. There is no buffering, and tx_data changes after accept have no effect.
- Tick counter: a log2(OVERSAMPLE)-bit counter that increments only on tick16.
  - A bit period ends on the tick16 pulse where counter==OVERSAMPLE-1; the counter wraps to 0 on that pulse.
  - Cycles without tick16 hold all state.
- START: drives 0. At bit end it goes to DATA with bit counter=0.
- DATA: drives shreg[0].
  - At each bit end the shift register shifts right and the bit counter increments.
  - After bit DATA_BITS-1 ends, the next state is PARITY if enabled, else STOP.
- STOP: drives 1 for STOP_BITS bit periods.
  - At the final bit end, tx_done=1 for exactly that one clk and the state goes to IDLE.
  - tx_ready rises at the same edge.
- Back-to-back: a word presented with tx_valid held high is accepted on the first clk after tx_done. The idle gap is 1 clk, with the line high.
- tx_serial is registered and glitch-free, with no combinational path from inputs.
- tx_busy = (state != IDLE), registered.
- A tick16 pulse in the same cycle as accept is not counted toward the start bit. The start bit lasts exactly OVERSAMPLE counted ticks after accept.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - Parity is computed at accept as XOR of tx_data[DATA_BITS-1:0], inverted when PARITY_ODD=1.
  - The PARITY state drives that bit for one bit period between DATA and STOP.
  - Frame length becomes 1+DATA_BITS+1+STOP_BITS bits.
- Not defined: the PARITY state and its logic are absent, and the frame goes DATA to STOP directly.

Test Plan:
1. Reset then idle: hold rst=0 for 3 clk, release, no tx_valid for 50 clk -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
2. Single frame, defaults, tick16 tied high: send 0xA5 -> tx_serial = 0,1,0,1,0,0,1,0,1,1, each level held 16 clk. tx_done pulses once, 160 clk after accept. tx_busy is high for exactly 160 clk.
3. Sparse tick: tick16 every 4th clk, send 0x01 -> each bit lasts 64 clk, with sequence 0,1,0,0,0,0,0,0,0,1. Changing tx_data mid-frame does not alter the output.
4. Back-to-back: tx_valid held high with 0x00 then 0xFF -> second start bit begins 1 clk after the first tx_done, with no missed or duplicated frame.
5. Reset mid-frame: assert rst=0 during data bit 3 of 0x0F -> tx_serial=1 at that edge, tx_done never pulses. The next frame after release is clean.
6. Parity (UART_TX_PARITY_EN, PARITY_ODD=0), tick16 high: send 0x07 -> parity bit=1 after data, frame is 11 bits = 176 clk. With PARITY_ODD=1 the parity bit is 0.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Purpose: UART transmit serializer: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Latency: start bit appears on tx_serial 1 clk after accept; each bit lasts OVERSAMPLE tick16 pulses.
// Backpressure: tx_ready is high only in IDLE; tx_valid while busy is ignored and there is no buffering.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous active-low reset
//   tick16    oversample enable, one pulse per 1/OVERSAMPLE bit time
//   tx_data   word to send, latched on accept
//   tx_valid  producer has a word
//   tx_ready  block can accept a word (IDLE only)
//   tx_serial serial line, idle high, registered
//   tx_busy   frame in progress, registered
//   tx_done   one-clk pulse at the end of the last stop bit
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1)
// between the data bits and the stop bits.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick16,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    // Elaboration-time parameter sanity checks.
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data_bits
        $error("uart_tx_serializer: DATA_BITS must be 5..8");
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 16 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_chk_oversample
        $error("uart_tx_serializer: OVERSAMPLE must be a power of two in 4..16");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_parity_odd
        $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t               state,   state_nxt;
    logic [TW-1:0]        cnt,     cnt_nxt;
    logic [BW-1:0]        bitcnt,  bitcnt_nxt;
    logic [DATA_BITS-1:0] shreg,   shreg_nxt;
    logic                 done_nxt;
    logic                 serial_nxt;
    logic                 busy_nxt;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    logic                 par_bit, par_nxt;
`endif

    // A bit period closes on the tick that would wrap the counter.
    assign bit_end  = tick16 && (cnt == TICK_LAST);
    assign tx_ready = (state == S_IDLE);

    // State register: FSM state, datapath and the registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bitcnt    <= bitcnt_nxt;
            shreg     <= shreg_nxt;
            tx_serial <= serial_nxt;
            tx_busy   <= busy_nxt;
            tx_done   <= done_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_bit <= 1'b0;
        end else begin
            par_bit <= par_nxt;
        end
    end
`endif

    // Next-state and datapath update.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        done_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt    = par_bit;
`endif

        // Ticks only count once a frame is underway, so a tick coincident
        // with accept does not shorten the start bit.
        if (state != S_IDLE && tick16) begin
            cnt_nxt = cnt + TW'(1);
        end

        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    state_nxt  = S_START;
                    cnt_nxt    = '0;
                    bitcnt_nxt = '0;
                    shreg_nxt  = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_nxt    = (^tx_data) ^ PARITY_ODD[0];
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt  = S_DATA;
                    bitcnt_nxt = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_nxt = shreg >> 1;
                    if (bitcnt == DATA_LAST) begin
                        bitcnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        state_nxt  = S_PARITY;
`else
                        state_nxt  = S_STOP;
`endif
                    end else begin
                        bitcnt_nxt = bitcnt + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt  = S_STOP;
                    bitcnt_nxt = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bitcnt == STOP_LAST) begin
                        state_nxt  = S_IDLE;
                        bitcnt_nxt = '0;
                        done_nxt   = 1'b1;
                    end else begin
                        bitcnt_nxt = bitcnt + BW'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the line and busy flag are
    // registered alongside the state they describe.
    always_comb begin
        serial_nxt = 1'b1;
        busy_nxt   = (state_nxt != S_IDLE);
        case (state_nxt)
            S_START:  serial_nxt = 1'b0;
            S_DATA:   serial_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: serial_nxt = par_nxt;
`endif
            default:  serial_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    localparam int DB   = 8;
    localparam int OS   = 16;
    localparam int SB   = 1;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 1 + DB + PB + SB;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          tick16   = 1'b0;
    logic [DB-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;
    logic          tx_done;

    uart_tx_serializer #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .STOP_BITS (SB),
        .PARITY_ODD(PODD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick16   (tick16),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_serial(tx_serial),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expected line level for each bit of each frame, in order.
    bit [15:0] exp_q[$];

    int tick_mode = 0;   // 0: every clk, 1: every tick_div clk, 2: random
    int tick_div  = 4;

    // Reference frame: start 0, data LSB first, optional parity, stop 1s.
    function automatic bit [15:0] frame_of(input logic [DB-1:0] d);
        bit [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1+i] = d[i];
        if (PB != 0) f[1+DB] = (^d) ^ (PODD != 0);
        return f;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic fin_bit(input int fr, input int b, input int nbad, input bit lvl);
        n_tests++;
        if (nbad != 0) begin
            n_fail++;
            $display("FAIL frame%0d_bit%0d: %0d cycles wrong, required line=%0b busy=1 done=0 ready=0",
                     fr, b, nbad, lvl);
        end
    endtask

    // Tick generator, driven just after the active edge.
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            case (tick_mode)
                0:       tick16 = 1'b1;
                1:       begin tick16 = ((c % tick_div) == 0); c++; end
                default: tick16 = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor state.
    bit        m_armed  = 0;
    bit        m_active = 0;
    int        m_ticks  = 0;
    int        m_cur    = 0;
    int        m_bad    = 0;
    int        m_frame  = 0;
    bit [15:0] m_fr     = '1;

    // Monitor: samples on the falling edge, expects the line level of bit
    // floor(ticks/OS), where ticks counts tick16 pulses after the accept edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_armed) begin
                if (m_active) begin
                    if (m_ticks == NB * OS) begin
                        fin_bit(m_frame, m_cur, m_bad, m_fr[m_cur]);
                        check($sformatf("frame%0d_done", m_frame), int'(tx_done), 1);
                        check($sformatf("frame%0d_busy_end", m_frame), int'(tx_busy), 0);
                        check($sformatf("frame%0d_line_end", m_frame), int'(tx_serial), 1);
                        check($sformatf("frame%0d_ready_end", m_frame), int'(tx_ready), 1);
                        m_active = 0;
                    end else begin
                        if (m_ticks / OS != m_cur) begin
                            fin_bit(m_frame, m_cur, m_bad, m_fr[m_cur]);
                            m_cur = m_ticks / OS;
                            m_bad = 0;
                        end
                        if (tx_serial !== m_fr[m_cur] || tx_busy !== 1'b1 ||
                            tx_done !== 1'b0 || tx_ready !== 1'b0)
                            m_bad++;
                    end
                end else begin
                    check("idle_srbd", int'({tx_serial, tx_ready, tx_busy, tx_done}), 4'b1100);
                end
            end

            if (!rst) begin
                if (m_active) fin_bit(m_frame, m_cur, m_bad, m_fr[m_cur]);
                m_active = 0;
                m_armed  = 1;
            end else if (m_armed) begin
                if (m_active && tick16) m_ticks++;
                if (!m_active && tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_accept: accept with empty queue, expected none");
                        m_fr = '1;
                    end else begin
                        m_fr = exp_q.pop_front();
                    end
                    m_frame++;
                    m_active = 1;
                    m_ticks  = 0;
                    m_cur    = 0;
                    m_bad    = 0;
                end
            end
        end
    end

    // Driver: queue the expected frame, present the word, wait for accept.
    task automatic send(input logic [DB-1:0] d, input bit hold);
        int  k;
        bit  acc;
        exp_q.push_back(frame_of(d));
        tx_data  = d;
        tx_valid = 1'b1;
        k   = 0;
        acc = 0;
        while (!acc && k < 5000) begin
            @(negedge clk);
            acc = tx_ready && rst;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: no accept in %0d clk, expected accept", k);
        end
        if (!hold) tx_valid = 1'b0;
        // Later changes to tx_data must not reach the line.
        tx_data = DB'($urandom);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || tx_ready !== 1'b1) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d frames pending, ready=%0b, expected idle", exp_q.size(), tx_ready);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Idle after reset.
        repeat (50) @(posedge clk);
        #1;

        // Single frame, tick every clk.
        tick_mode = 0;
        send(8'hA5, 0);
        drain(2000);

        // Sparse tick, every 4th clk.
        tick_mode = 1;
        tick_div  = 4;
        send(8'h01, 0);
        drain(5000);

        // Back-to-back with tx_valid held.
        tick_mode = 0;
        send(8'h00, 1);
        send(8'hFF, 0);
        drain(2000);

        // Reset during data bit 3, then a clean frame.
        send(8'h0F, 0);
        repeat (70) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(8'h3C, 0);
        drain(2000);

        // Randomized frames, tick patterns and gaps.
        for (int i = 0; i < 25; i++) begin
            bit hold;
            tick_mode = $urandom_range(0, 2);
            tick_div  = $urandom_range(1, 3);
            hold      = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
            send(DB'($urandom), hold);
            if (!hold) begin
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
            end
        end
        drain(20000);
        repeat (20) @(posedge clk);
        #1;

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
